// File: rtl/sort_pkg.sv
// Shared types and constants for the eight-entry sort block.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    CMP,
    SWAP,
    DONE
  } state_t;

  localparam int DEPTH = 8;

  localparam logic [1:0] WM_IN   = 2'd0;
  localparam logic [1:0] WM_TEMP = 2'd1;
  localparam logic [1:0] WM_HIGH = 2'd2;

endpackage

// File: rtl/sort_control.sv
// Load-then-bubble-sort controller for the 8x4 sort datapath.
// Shadow pointers track the datapath counters, which have no clear.
module sort_control
  import sort_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       gte,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       mem_en,
  output logic       low_en,
  output logic       high_en,
  output logic       temp_en,
  output logic       stat_en,
  output logic [1:0] writemux
);

  state_t     state_q, state_d;
  logic [2:0] sl_q, sl_d;
  logic [2:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic       swapped_q, swapped_d;

  logic wrap;
  logic aligned;

  assign wrap    = (sl_q == 3'(DEPTH - 1));
  assign aligned = (sh_q == sl_q + 3'd1);

  assign in_ready = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swapped_d = swapped_q;
    mem_en    = 1'b0;
    low_en    = 1'b0;
    high_en   = 1'b0;
    temp_en   = 1'b0;
    stat_en   = 1'b0;
    writemux  = WM_IN;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = 3'd0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          mem_en = 1'b1;
          low_en = 1'b1;
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'(DEPTH - 1)) begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (!aligned) begin
          high_en = 1'b1;
        end else begin
          swapped_d = 1'b0;
          state_d   = CMP;
        end
      end
      CMP: begin
        // Slot 7 has no partner; it only re-wraps both pointers.
        if (wrap) begin
          low_en  = 1'b1;
          high_en = 1'b1;
          if (!swapped_q) begin
            state_d = DONE;
          end else begin
            swapped_d = 1'b0;
          end
        end else begin
          stat_en = 1'b1;
          low_en  = 1'b1;
          if (gte) begin
            high_en = 1'b1;
          end else begin
            temp_en  = 1'b1;
            mem_en   = 1'b1;
            writemux = WM_HIGH;
            state_d  = SWAP;
          end
        end
      end
      SWAP: begin
        mem_en    = 1'b1;
        writemux  = WM_TEMP;
        high_en   = 1'b1;
        swapped_d = 1'b1;
        state_d   = CMP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sl_d = sl_q + {2'b00, low_en};
  assign sh_d = sh_q + {2'b00, high_en};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sl_q      <= 3'd0;
      sh_q      <= 3'd0;
      cnt_q     <= 3'd0;
      swapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sl_q      <= sl_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      swapped_q <= swapped_d;
    end
  end

endmodule
